// File: rtl/noc_pkt_tx.sv
// noc_pkt_tx: NoC output packetizer emitting a header flit then buffered payload flits on AXI-Stream
module noc_pkt_tx #(
  parameter int XY_SZ   = 4,
  parameter int LEN_SZ  = 8,
  parameter int FIFO_AW = 3
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_high,
  input  logic [2*XY_SZ-1:0]   HsrcId,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [XY_SZ-1:0]     cmd_dest_x,
  input  logic [XY_SZ-1:0]     cmd_dest_y,
  input  logic [LEN_SZ-1:0]    cmd_len,
  input  logic                 pld_valid,
  input  logic [31:0]          pld_data,
  output logic                 pld_ready,
  input  logic                 stream_out_TREADY,
  output logic                 stream_out_TVALID,
  output logic [31:0]          stream_out_TDATA,
  output logic [3:0]           stream_out_TKEEP,
  output logic                 stream_out_TLAST,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t                state_q, state_d;
  logic [XY_SZ-1:0]      dx_q, dy_q;
  logic [2*XY_SZ-1:0]    src_q;
  logic [LEN_SZ-1:0]     len_q, rem_q, rem_d;
  logic [31:0]           mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0]    wp_q, rp_q;
  logic [FIFO_AW:0]      cnt_q;
  logic [31:0]           hdr;
  logic                  empty, push, pop, cmd_fire;

  assign empty            = cnt_q == '0;
  assign pld_ready        = !cnt_q[FIFO_AW];
  assign push             = pld_valid && pld_ready;
  assign pop              = state_q == DATA && !empty && stream_out_TREADY;
  assign cmd_ready        = state_q == IDLE && !clk_line_rst_high;
  assign cmd_fire         = cmd_valid && cmd_ready;
  assign busy             = state_q != IDLE;
  assign stream_out_TKEEP = 4'hF;
  assign hdr              = {dx_q, dy_q, src_q, (32-4*XY_SZ)'(len_q)};

  // next state and flit outputs; the flit is a pure function of state so it holds while stalled
  always_comb begin
    state_d           = state_q;
    rem_d             = rem_q;
    stream_out_TVALID = 1'b0;
    stream_out_TDATA  = '0;
    stream_out_TLAST  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = cmd_fire ? HDR : IDLE;
        rem_d   = cmd_fire ? cmd_len : rem_q;
      end
      HDR: begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = hdr;
        stream_out_TLAST  = len_q == '0;
        state_d           = !stream_out_TREADY ? HDR : (len_q == '0 ? IDLE : DATA);
      end
      DATA: begin
        stream_out_TVALID = !empty;
        stream_out_TDATA  = mem_q[rp_q];
        stream_out_TLAST  = !empty && rem_q == LEN_SZ'(1);
        rem_d             = pop ? rem_q - LEN_SZ'(1) : rem_q;
        state_d           = pop && rem_q == LEN_SZ'(1) ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, latched command fields and FIFO bookkeeping
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      state_q <= IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      src_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= cmd_fire ? cmd_len : len_q;
      dx_q    <= cmd_fire ? cmd_dest_x : dx_q;
      dy_q    <= cmd_fire ? cmd_dest_y : dy_q;
      src_q   <= cmd_fire ? HsrcId : src_q;
      wp_q    <= wp_q + FIFO_AW'(push);
      rp_q    <= rp_q + FIFO_AW'(pop);
      cnt_q   <= cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  // payload storage needs no reset; only pointers define its contents
  always_ff @(posedge clk_line) begin
    if (push) mem_q[wp_q] <= pld_data;
  end
endmodule

// File: tb/tb_noc_pkt_tx.sv
// tb_noc_pkt_tx: directed self-checking bench for noc_pkt_tx
module tb_noc_pkt_tx;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  src = 8'h12;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  dx = '0, dy = '0;
  logic [7:0]  len = '0;
  logic        pld_valid = 1'b0, pld_ready;
  logic [31:0] pld_data = '0;
  logic        tready = 1'b0, tvalid, tlast, busy;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  int          n_chk = 0, n_err = 0, cyc = 0;
  logic [32:0] got_q [$];
  int          got_c [$];
  logic        p_stall = 1'b0;
  logic [33:0] p_flit = '0;

  noc_pkt_tx dut (
    .clk_line(clk), .clk_line_rst_high(rst), .HsrcId(src),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest_x(dx), .cmd_dest_y(dy), .cmd_len(len),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
    .stream_out_TREADY(tready), .stream_out_TVALID(tvalid), .stream_out_TDATA(tdata),
    .stream_out_TKEEP(tkeep), .stream_out_TLAST(tlast), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) p_stall = 1'b0;
    else begin
      if (p_stall) chk("stable", {tvalid, tlast, tdata}, p_flit);
      if (tvalid && tready) begin
        got_q.push_back({tlast, tdata});
        got_c.push_back(cyc);
      end
      p_stall = tvalid && !tready;
      p_flit  = {tvalid, tlast, tdata};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    logic acc;
    int b = 0;
    pld_data  = d;
    pld_valid = 1'b1;
    do begin
      acc = pld_ready;
      tick;
      b++;
    end while (!acc && b < 100);
    pld_valid = 1'b0;
    chk("push_acc", 34'(acc), 34'd1);
  endtask

  task automatic send_cmd(input logic [3:0] x, input logic [3:0] y, input logic [7:0] l);
    logic acc;
    int b = 0;
    dx = x;
    dy = y;
    len = l;
    cmd_valid = 1'b1;
    do begin
      acc = cmd_ready;
      tick;
      b++;
    end while (!acc && b < 100);
    cmd_valid = 1'b0;
    chk("cmd_acc", 34'(acc), 34'd1);
  endtask

  task automatic wait_flits(input int n);
    int b = 0;
    while (got_q.size() < n && b < 300) begin
      tick;
      b++;
    end
    repeat (3) tick;
    chk("nflit", 34'(got_q.size()), 34'(n));
  endtask

  task automatic flit(input int i, input logic l, input logic [31:0] d);
    chk($sformatf("flit%0d", i), 34'(got_q[i]), {1'b0, l, d});
  endtask

  initial begin
    tick;
    tick;
    chk("rst_tvalid", 34'(tvalid), 34'd0);
    chk("rst_tlast", 34'(tlast), 34'd0);
    chk("rst_tdata", 34'(tdata), 34'd0);
    chk("rst_busy", 34'(busy), 34'd0);
    chk("rst_cmd_ready", 34'(cmd_ready), 34'd0);
    rst = 1'b0;
    tick;
    chk("post_pld_ready", 34'(pld_ready), 34'd1);
    chk("post_cmd_ready", 34'(cmd_ready), 34'd1);
    chk("tkeep", 34'(tkeep), 34'hF);
    tready = 1'b1;

    got_q.delete(); got_c.delete();
    for (int i = 0; i < 3; i++) push(32'hA0 + i);
    send_cmd(4'd3, 4'd5, 8'd3);
    chk("b_hdr_valid", 34'(tvalid), 34'd1);
    chk("b_hdr_data", 34'(tdata), 34'h35120003);
    chk("b_busy", 34'(busy), 34'd1);
    wait_flits(4);
    flit(0, 1'b0, 32'h35120003);
    for (int i = 0; i < 3; i++) flit(i + 1, i == 2, 32'hA0 + i);

    got_q.delete(); got_c.delete();
    send_cmd(4'd1, 4'd2, 8'd0);
    chk("h_tlast", 34'(tlast), 34'd1);
    chk("h_tdata", 34'(tdata), 34'h12120000);
    tick;
    chk("h_idle_busy", 34'(busy), 34'd0);
    chk("h_idle_ready", 34'(cmd_ready), 34'd1);
    chk("h_idle_tvalid", 34'(tvalid), 34'd0);
    wait_flits(1);
    flit(0, 1'b1, 32'h12120000);

    got_q.delete(); got_c.delete();
    for (int i = 0; i < 4; i++) push(32'hB0 + i);
    send_cmd(4'd7, 4'd9, 8'd4);
    for (int b = 0; b < 200 && got_q.size() < 5; b++) begin
      tready = ~tready;
      tick;
    end
    tready = 1'b1;
    wait_flits(5);
    flit(0, 1'b0, 32'h79120004);
    for (int i = 0; i < 4; i++) flit(i + 1, i == 3, 32'hB0 + i);

    got_q.delete(); got_c.delete();
    for (int i = 0; i < 8; i++) push(32'hC000_0000 + i);
    chk("full_ready", 34'(pld_ready), 34'd0);
    pld_data = 32'hDEAD;
    pld_valid = 1'b1;
    tick;
    tick;
    chk("full_hold_ready", 34'(pld_ready), 34'd0);
    pld_valid = 1'b0;
    send_cmd(4'd2, 4'd4, 8'd10);
    push(32'hC000_0008);
    push(32'hC000_0009);
    wait_flits(11);
    flit(0, 1'b0, 32'h2412000A);
    for (int i = 0; i < 10; i++) flit(i + 1, i == 9, 32'hC000_0000 + i);

    got_q.delete(); got_c.delete();
    send_cmd(4'd5, 4'd6, 8'd2);
    dx = 4'd8; dy = 4'd9; len = 8'd0;
    cmd_valid = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("gap_tvalid", 34'(tvalid), 34'd0);
      chk("gap_cmd_ready", 34'(cmd_ready), 34'd0);
      tick;
    end
    push(32'hD0);
    push(32'hD1);
    send_cmd(4'd8, 4'd9, 8'd0);
    wait_flits(4);
    flit(0, 1'b0, 32'h56120002);
    flit(1, 1'b0, 32'hD0);
    flit(2, 1'b1, 32'hD1);
    flit(3, 1'b1, 32'h89120000);
    chk("b2b_gap", 34'(got_c[3] - got_c[2]), 34'd2);

    got_q.delete(); got_c.delete();
    for (int i = 0; i < 3; i++) push(32'hE0 + i);
    send_cmd(4'd3, 4'd3, 8'd5);
    tick;
    tready = 1'b0;
    chk("pre_rst_data", 34'(tdata), 34'hE0);
    rst = 1'b1;
    tick;
    chk("mid_rst_tvalid", 34'(tvalid), 34'd0);
    chk("mid_rst_busy", 34'(busy), 34'd0);
    chk("mid_rst_tlast", 34'(tlast), 34'd0);
    rst = 1'b0;
    tick;
    chk("rel_pld_ready", 34'(pld_ready), 34'd1);
    chk("rel_cmd_ready", 34'(cmd_ready), 34'd1);
    tready = 1'b1;
    got_q.delete(); got_c.delete();
    send_cmd(4'd1, 4'd1, 8'd1);
    repeat (3) tick;
    chk("flushed_tvalid", 34'(tvalid), 34'd0);
    chk("flushed_busy", 34'(busy), 34'd1);
    push(32'hF0);
    wait_flits(2);
    flit(0, 1'b0, 32'h11120001);
    flit(1, 1'b1, 32'hF0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
